// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper blocks.
//   MINE_BIT / COUNT_MSB : board cell encoding (bit 4 = mine, bits 3:0 = adjacent count)
//   state_t              : reveal_engine FSM states
//   NEIGH_DX / NEIGH_DY  : neighbour offsets in reveal scan order
package minesweeper_pkg;

  localparam int MINE_BIT  = 4;
  localparam int COUNT_MSB = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    WAIT  = 3'd2,
    EVAL  = 3'd3,
    NEIGH = 3'd4,
    FIN   = 3'd5
  } state_t;

  // Scan order: (-1,-1) (0,-1) (+1,-1) (-1,0) (+1,0) (-1,+1) (0,+1) (+1,+1)
  localparam logic signed [1:0] NEIGH_DX [8] =
    '{2'b11, 2'b00, 2'b01, 2'b11, 2'b01, 2'b11, 2'b00, 2'b01};
  localparam logic signed [1:0] NEIGH_DY [8] =
    '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};

endpackage

// File: rtl/coord_fifo.sv
// Synchronous FIFO of packed {y,x} cell coordinates.
//   clk, reset      : clock, synchronous active-high reset
//   push, push_data : write one entry
//   pop             : discard the head entry (ignored when empty)
//   flush           : drop all entries (wins over push/pop)
//   head, empty     : current head entry (valid when !empty), empty flag
module coord_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];

  // NOTE: storage is not reset; pointers and count alone define which entries
  // are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reveal_engine.sv
// Breadth-first flood-fill reveal controller for minesweeper.
//   clk, reset            : clock, synchronous active-high reset
//   start, start_x/y      : click pulse and clicked cell
//   board_ready, num_mines: board initialised flag and mine count
//   rd_x/rd_y, rd_val     : board read address and cell value (1-cycle latency)
//   disp_x/y, disp_revealed : display query of the revealed bitmap (1-cycle latency)
//   busy, done            : fill in progress, end-of-click pulse
//   lost, won             : sticky game-over flags
//   reveal_count          : number of revealed cells
module reveal_engine
  import minesweeper_pkg::*;
#(
  parameter int X_SIZE = 16,
  parameter int Y_SIZE = 16,
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [X_BITS-1:0]        start_x,
  input  logic [Y_BITS-1:0]        start_y,
  input  logic                     board_ready,
  input  logic [X_BITS+Y_BITS-1:0] num_mines,
  output logic [X_BITS-1:0]        rd_x,
  output logic [Y_BITS-1:0]        rd_y,
  input  logic [4:0]               rd_val,
  input  logic [X_BITS-1:0]        disp_x,
  input  logic [Y_BITS-1:0]        disp_y,
  output logic                     disp_revealed,
  output logic                     busy,
  output logic                     done,
  output logic                     lost,
  output logic                     won,
  output logic [X_BITS+Y_BITS:0]   reveal_count
);

  localparam int IDX_W   = X_BITS + Y_BITS;
  localparam int CNT_W   = IDX_W + 1;
  localparam int N_CELLS = X_SIZE * Y_SIZE;
  localparam logic [X_BITS:0] X_LIM = (X_BITS + 1)'(X_SIZE);
  localparam logic [Y_BITS:0] Y_LIM = (Y_BITS + 1)'(Y_SIZE);

  function automatic logic [IDX_W-1:0] cell_idx(input logic [X_BITS-1:0] x,
                                                input logic [Y_BITS-1:0] y);
    return IDX_W'(y) * IDX_W'(Y_SIZE > 0 ? X_SIZE : 1) + IDX_W'(x);
  endfunction

  state_t             state, state_next;
  logic [N_CELLS-1:0] revealed;
  logic [2:0]         nidx;

  logic               mark, push, pop, flush, fifo_empty;
  logic [IDX_W-1:0]   mark_idx, push_data, head;

  logic signed [1:0]  dx, dy;
  logic [X_BITS:0]    nx;
  logic [Y_BITS:0]    ny;
  logic               n_in;
  logic [IDX_W-1:0]   n_idx, start_idx, disp_idx;
  logic [CNT_W-1:0]   win_target;

  // Neighbour coordinates one bit wider than the board: a step below 0 or past
  // the top edge lands at >= 2**BITS, so a single unsigned compare against the
  // board size rejects both sides without wrapping.
  assign dx    = NEIGH_DX[nidx];
  assign dy    = NEIGH_DY[nidx];
  assign nx    = {1'b0, rd_x} + {{(X_BITS-1){dx[1]}}, dx};
  assign ny    = {1'b0, rd_y} + {{(Y_BITS-1){dy[1]}}, dy};
  assign n_in  = (nx < X_LIM) && (ny < Y_LIM);
  assign n_idx = cell_idx(nx[X_BITS-1:0], ny[Y_BITS-1:0]);

  assign start_idx  = cell_idx(start_x, start_y);
  assign disp_idx   = cell_idx(disp_x, disp_y);
  assign win_target = CNT_W'(N_CELLS) - CNT_W'(num_mines);

  coord_fifo #(.WIDTH(IDX_W), .DEPTH(N_CELLS)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .empty     (fifo_empty)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == FIN);
    mark       = 1'b0;
    mark_idx   = '0;
    push       = 1'b0;
    push_data  = '0;
    pop        = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (start && board_ready && !lost && !won) begin
          if (!revealed[start_idx]) begin
            mark       = 1'b1;
            mark_idx   = start_idx;
            push       = 1'b1;
            push_data  = {start_y, start_x};
            state_next = POP;
          end else begin
            state_next = FIN;
          end
        end
      end
      POP: begin
        pop        = 1'b1;
        state_next = WAIT;
      end
      WAIT: state_next = EVAL;
      EVAL: begin
        if (rd_val[MINE_BIT]) begin
          flush      = 1'b1;
          state_next = FIN;
        end else if (rd_val[COUNT_MSB:0] != '0) begin
          state_next = fifo_empty ? FIN : POP;
        end else begin
          state_next = NEIGH;
        end
      end
      NEIGH: begin
        // Marking on push keeps each cell in the FIFO at most once.
        if (n_in && !revealed[n_idx]) begin
          mark      = 1'b1;
          mark_idx  = n_idx;
          push      = 1'b1;
          push_data = {ny[Y_BITS-1:0], nx[X_BITS-1:0]};
        end
        // fifo_empty does not yet reflect a push made in this same cycle.
        if (nidx == 3'd7) state_next = (fifo_empty && !push) ? FIN : POP;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this also makes a same-cycle display read of a
  // cell being marked return its old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      revealed      <= '0;
      reveal_count  <= '0;
      rd_x          <= '0;
      rd_y          <= '0;
      nidx          <= '0;
      lost          <= 1'b0;
      won           <= 1'b0;
      disp_revealed <= 1'b0;
    end else begin
      state         <= state_next;
      disp_revealed <= revealed[disp_idx];
      if (mark) begin
        revealed[mark_idx] <= 1'b1;
        reveal_count       <= reveal_count + 1'b1;
      end
      if (state == POP) begin
        rd_x <= head[X_BITS-1:0];
        rd_y <= head[IDX_W-1:X_BITS];
      end
      nidx <= (state == NEIGH) ? nidx + 3'd1 : 3'd0;
      if (state == EVAL && rd_val[MINE_BIT]) lost <= 1'b1;
      if (state == FIN && !lost && reveal_count == win_target) won <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reveal_engine.sv
// Self-checking bench for reveal_engine: a registered board model answers
// reads, a flood-fill reference model predicts the revealed set, counters,
// flags and click latency, and one compare process checks the DUT against it.
module tb_reveal_engine;

  localparam int XS = 16;
  localparam int YS = 16;
  localparam int NC = XS * YS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] start_x = '0;
  logic [3:0] start_y = '0;
  logic       board_ready = 1'b1;
  logic [7:0] num_mines = '0;
  logic [3:0] rd_x, rd_y;
  logic [4:0] rd_val = '0;
  logic [3:0] disp_x = '0;
  logic [3:0] disp_y = '0;
  logic       disp_revealed, busy, done, lost, won;
  logic [8:0] reveal_count;

  reveal_engine #(.X_SIZE(XS), .Y_SIZE(YS), .X_BITS(4), .Y_BITS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_x       (start_x),
    .start_y       (start_y),
    .board_ready   (board_ready),
    .num_mines     (num_mines),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .rd_val        (rd_val),
    .disp_x        (disp_x),
    .disp_y        (disp_y),
    .disp_revealed (disp_revealed),
    .busy          (busy),
    .done          (done),
    .lost          (lost),
    .won           (won),
    .reveal_count  (reveal_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- board model ----------------
  bit mine_map [NC];
  int nmines;

  task automatic clear_board();
    for (int i = 0; i < NC; i++) mine_map[i] = 1'b0;
    nmines = 0;
    num_mines = '0;
  endtask

  task automatic set_mine(input int x, input int y);
    mine_map[y*XS + x] = 1'b1;
    nmines++;
    num_mines = nmines[7:0];
  endtask

  function automatic logic [4:0] cell_val(input int x, input int y);
    int n = 0;
    for (int ddy = -1; ddy <= 1; ddy++)
      for (int ddx = -1; ddx <= 1; ddx++)
        if (!(ddx == 0 && ddy == 0) && x+ddx >= 0 && x+ddx < XS && y+ddy >= 0 && y+ddy < YS)
          if (mine_map[(y+ddy)*XS + x+ddx]) n++;
    return {mine_map[y*XS + x], n[3:0]};
  endfunction

  always @(posedge clk) rd_val <= cell_val(int'(rd_x), int'(rd_y));

  // ---------------- reference model ----------------
  bit [NC-1:0] exp_rev = '0;
  int exp_count = 0;
  bit exp_lost = 0;
  bit exp_won  = 0;
  bit pending  = 1;

  // Predicts the effect of one click; lat = cycles from the start edge to done,
  // or -1 when the click must be dropped.
  task automatic model_click(input int x, input int y, output int lat);
    int q[$];
    int c, cx, cy, cells, zeros;
    logic [4:0] v;
    lat = -1;
    if (!board_ready || exp_lost || exp_won) return;
    c = y*XS + x;
    if (exp_rev[c]) begin
      lat = 1;
      return;
    end
    exp_rev[c] = 1'b1;
    exp_count++;
    q.push_back(c);
    cells = 0;
    zeros = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      cells++;
      cx = c % XS;
      cy = c / XS;
      if (mine_map[c]) begin
        exp_lost = 1'b1;
        q.delete();
        break;
      end
      v = cell_val(cx, cy);
      if (v[3:0] != 4'd0) continue;
      zeros++;
      for (int ddy = -1; ddy <= 1; ddy++)
        for (int ddx = -1; ddx <= 1; ddx++)
          if (!(ddx == 0 && ddy == 0) && cx+ddx >= 0 && cx+ddx < XS && cy+ddy >= 0 && cy+ddy < YS)
            if (!exp_rev[(cy+ddy)*XS + cx+ddx]) begin
              exp_rev[(cy+ddy)*XS + cx+ddx] = 1'b1;
              exp_count++;
              q.push_back((cy+ddy)*XS + cx+ddx);
            end
    end
    lat = 1 + 3*cells + 8*zeros;
    if (!exp_lost && exp_count == NC - nmines) exp_won = 1'b1;
  endtask

  // ---------------- compare process ----------------
  logic       busy_q = 1'b0;
  logic [7:0] prev_disp = '0;
  always @(posedge clk) begin
    busy_q    <= busy;
    prev_disp <= {disp_y, disp_x};
  end

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (pending) begin
        // Once a fill has popped its first cell, every read address must be a
        // cell the fill legitimately reveals (catches wrapped neighbours).
        if (busy === 1'b1 && busy_q === 1'b1)
          check("rd_addr_in_fill", exp_rev[{rd_y, rd_x}], 1);
      end else begin
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("reveal_count", reveal_count, exp_count);
        check("lost", lost, exp_lost);
        check("won", won, exp_won);
        check("disp_revealed", disp_revealed, exp_rev[prev_disp]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    pending = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lost", lost, 0);
    check("rst_won", won, 0);
    check("rst_count", reveal_count, 0);
    check("rst_rd_x", rd_x, 0);
    check("rst_rd_y", rd_y, 0);
    check("rst_disp", disp_revealed, 0);
    reset = 1'b0;
    exp_rev = '0;
    exp_count = 0;
    exp_lost = 1'b0;
    exp_won = 1'b0;
    @(negedge clk);
    pending = 1'b0;
  endtask

  // Clicks (x,y); optionally pulses a second start at (ix,iy) inj cycles later.
  task automatic run_click(input int x, input int y, input int inj,
                           input int ix, input int iy, output int seen);
    int lat, budget;
    @(negedge clk);
    model_click(x, y, lat);
    if (lat >= 0) pending = 1'b1;
    start = 1'b1;
    start_x = x[3:0];
    start_y = y[3:0];
    @(negedge clk);
    seen = -1;
    budget = (lat >= 0) ? lat + 20 : 12;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (cyc == inj) begin
        start = 1'b1;
        start_x = ix[3:0];
        start_y = iy[3:0];
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        seen = cyc;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("click_latency", seen, lat);
    @(negedge clk);
    pending = 1'b0;
  endtask

  task automatic sweep_display();
    for (int i = 0; i < NC; i++) begin
      @(negedge clk);
      disp_x = i[3:0];
      disp_y = i[7:4];
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic disp_probe(input int x, input int y, input logic exp, input string name);
    @(negedge clk);
    disp_x = x[3:0];
    disp_y = y[3:0];
    @(negedge clk);
    check(name, disp_revealed, exp);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int seen, lat;

    clear_board();
    do_reset();

    // Board A: nonzero click, re-click, not-ready click, mine, post-loss click.
    set_mine(2, 2);
    set_mine(4, 4);
    set_mine(7, 7);
    run_click(3, 3, 0, 0, 0, seen);
    check("a_nonzero_latency", seen, 4);
    check("a_nonzero_count", reveal_count, 1);
    disp_probe(3, 3, 1'b1, "a_disp_33");
    disp_probe(4, 3, 1'b0, "a_disp_43");
    sweep_display();
    run_click(3, 3, 0, 0, 0, seen);
    check("a_reclick_latency", seen, 1);
    check("a_reclick_count", reveal_count, 1);
    @(negedge clk);
    board_ready = 1'b0;
    run_click(5, 5, 0, 0, 0, seen);
    @(negedge clk);
    board_ready = 1'b1;
    run_click(2, 2, 0, 0, 0, seen);
    check("a_mine_latency", seen, 4);
    check("a_mine_lost", lost, 1);
    check("a_mine_count", reveal_count, 2);
    run_click(12, 12, 0, 0, 0, seen);
    check("a_after_loss_count", reveal_count, 2);

    // Board B: single mine in the far corner; full flood from (0,0) with a
    // click on the mine while busy that must be ignored.
    do_reset();
    clear_board();
    set_mine(15, 15);
    run_click(0, 0, 50, 15, 15, seen);
    check("b_flood_latency", seen, 2782);
    check("b_model_count", exp_count, 255);
    check("b_flood_count", reveal_count, 255);
    check("b_flood_won", won, 1);
    check("b_flood_lost", lost, 0);
    disp_probe(15, 15, 1'b0, "b_disp_mine");
    disp_probe(14, 15, 1'b1, "b_disp_1415");
    run_click(15, 15, 0, 0, 0, seen);
    sweep_display();

    // Board C: corner zero region walled off by mines.
    do_reset();
    clear_board();
    set_mine(2, 0);
    set_mine(2, 1);
    set_mine(2, 2);
    set_mine(1, 2);
    set_mine(0, 2);
    run_click(0, 0, 0, 0, 0, seen);
    check("c_corner_latency", seen, 21);
    check("c_corner_count", reveal_count, 4);
    disp_probe(15, 0, 1'b0, "c_no_wrap_x");
    disp_probe(0, 15, 1'b0, "c_no_wrap_y");
    sweep_display();

    // Reset in the middle of a large fill, then a fresh click.
    do_reset();
    clear_board();
    set_mine(15, 15);
    @(negedge clk);
    model_click(0, 0, lat);
    pending = 1'b1;
    start = 1'b1;
    start_x = 4'd0;
    start_y = 4'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    check("mid_fill_busy", busy, 1);
    do_reset();
    clear_board();
    set_mine(2, 0);
    set_mine(2, 1);
    set_mine(2, 2);
    set_mine(1, 2);
    set_mine(0, 2);
    run_click(0, 0, 0, 0, 0, seen);
    check("post_reset_latency", seen, 21);
    check("post_reset_count", reveal_count, 4);
    sweep_display();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
